// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one full-subtractor cell, LSB first, valid/ready on both sides.
// Optional SERIAL_SUBTRACTOR_BIN_EN adds a borrow-in port sampled at accept.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
`ifdef SERIAL_SUBTRACTOR_BIN_EN
  input  logic             bin,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_d;
  logic             r_br;
  logic             r_bout;
  logic [CW-1:0]    r_cnt;

  logic w_bin;
  logic w_ai;
  logic w_bi;
  logic w_di;
  logic w_bo;
  logic w_last;

`ifdef SERIAL_SUBTRACTOR_BIN_EN
  assign w_bin = bin;
`else
  assign w_bin = 1'b0;
`endif

  // The single full-subtractor cell, fed from the operand shifters
  assign w_ai   = r_a[0];
  assign w_bi   = r_b[0];
  assign w_di   = w_ai ^ w_bi ^ r_br;
  assign w_bo   = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_br);
  assign w_last = (r_cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_d     <= '0;
      r_br    <= 1'b0;
      r_bout  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_acc   <= '0;
            r_br    <= w_bin;
            r_cnt   <= '0;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_br  <= w_bo;
          r_acc <= {w_di, r_acc[WIDTH-1:1]};
          r_cnt <= r_cnt + CW'(1);
          // Result registers only change on completion, so a reset
          // mid-shift never exposes a partial difference.
          if (w_last) begin
            r_d     <= {w_di, r_acc[WIDTH-1:1]};
            r_bout  <= w_bo;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE) & ~rst;
  assign out_valid = (r_state == S_DONE) & ~rst;
  assign d         = r_d;
  assign bout      = r_bout;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed + random bench for serial_subtractor (WIDTH=8).
// Borrow-in vectors are compiled only with SERIAL_SUBTRACTOR_BIN_EN.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] d;
  logic         bout;
  logic         bin_s;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_cnt = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef SERIAL_SUBTRACTOR_BIN_EN
    .bin       (bin_s),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .bout      (bout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] d;
    logic         bo;
  } vec_t;

  vec_t tv[8];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Entered #1 after a rising edge; returns #1 after the accept edge.
  task automatic do_accept(input logic [W-1:0] va, input logic [W-1:0] vb,
                           input logic vbin, output int acc_cyc);
    int g;
    g = 0;
    a = va;
    b = vb;
    bin_s = vbin;
    in_valid = 1'b1;
    while (!in_ready && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    if (!in_ready) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    acc_cyc = cyc_cnt;
  endtask

  // lat = cycle index (first SHIFT cycle is 1) at which out_valid is seen.
  task automatic wait_res(output logic [W-1:0] rd, output logic rb,
                          output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) chk("result_timeout", 0, 1);
    rd = d;
    rb = bout;
  endtask

  task automatic op(input logic [W-1:0] va, input logic [W-1:0] vb,
                    input logic vbin, input string nm,
                    input logic [W-1:0] ed, input logic eb);
    logic [W-1:0] rd;
    logic rb;
    int lat;
    int ac;
    out_ready = 1'b1;
    do_accept(va, vb, vbin, ac);
    in_valid = 1'b0;
    wait_res(rd, rb, lat);
    chk({nm, "_d"}, 32'(rd), 32'(ed));
    chk({nm, "_bout"}, 32'(rb), 32'(eb));
    chk({nm, "_lat"}, lat, W + 1);
    @(posedge clk); #1;
    chk({nm, "_idle"}, 32'(in_ready), 1);
  endtask

  initial begin
    logic [W-1:0] rd;
    logic         rb;
    logic [W:0]   full;
    int           lat;
    int           ac;
    int           prev_ac;
    int           hold_bad;

    tv[0] = '{8'h5A, 8'h23, 8'h37, 1'b0};
    tv[1] = '{8'h00, 8'h01, 8'hFF, 1'b1};
    tv[2] = '{8'hFF, 8'hFF, 8'h00, 1'b0};
    tv[3] = '{8'h10, 8'h08, 8'h08, 1'b0};
    tv[4] = '{8'h01, 8'h02, 8'hFF, 1'b1};
    tv[5] = '{8'h80, 8'h7F, 8'h01, 1'b0};
    tv[6] = '{8'h7F, 8'h80, 8'hFF, 1'b1};
    tv[7] = '{8'hC3, 8'h3C, 8'h87, 1'b0};

    rst = 1'b1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    bin_s = 1'b0;
    out_ready = 1'b0;
    #2;
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_d", 32'(d), 0);
    chk("rst_bout", 32'(bout), 0);
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 32'(in_ready), 1);

    for (int i = 0; i < 8; i++) begin
      op(tv[i].a, tv[i].b, 1'b0, $sformatf("vec%0d", i), tv[i].d, tv[i].bo);
    end

    // Result held under backpressure while new operands are offered
    out_ready = 1'b0;
    do_accept(8'h5A, 8'h23, 1'b0, ac);
    in_valid = 1'b0;
    wait_res(rd, rb, lat);
    chk("hold_lat", lat, W + 1);
    a = 8'hFF;
    b = 8'h01;
    in_valid = 1'b1;
    hold_bad = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (d !== 8'h37 || bout !== 1'b0 || in_ready !== 1'b0 ||
          out_valid !== 1'b1)
        hold_bad++;
    end
    chk("hold_stable", hold_bad, 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("hold_release_idle", 32'(in_ready), 1);
    chk("hold_release_ov", 32'(out_valid), 0);
    chk("hold_release_d", 32'(d), 32'h37);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_res(rd, rb, lat);
    chk("after_hold_d", 32'(rd), 32'hFE);
    chk("after_hold_bout", 32'(rb), 0);
    @(posedge clk); #1;

    // Reset during the bit-3 SHIFT cycle
    do_accept(8'h33, 8'h44, 1'b0, ac);
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 0);
    chk("midrst_out_valid", 32'(out_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst_idle", 32'(in_ready), 1);
    chk("midrst_d", 32'(d), 0);
    hold_bad = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) hold_bad++;
    end
    chk("midrst_no_result", hold_bad, 0);
    op(8'h10, 8'h08, 1'b0, "post_rst", 8'h08, 1'b0);

`ifdef SERIAL_SUBTRACTOR_BIN_EN
    op(8'h10, 8'h0F, 1'b1, "bin_a", 8'h00, 1'b0);
    op(8'h00, 8'h00, 1'b1, "bin_b", 8'hFF, 1'b1);
`endif

    // Back-to-back random pairs: one result per W+2 cycles
    out_ready = 1'b1;
    prev_ac = 0;
    for (int i = 0; i < 100; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rbv;
      logic         rbin;
      ra = W'($urandom_range(0, 255));
      rbv = W'($urandom_range(0, 255));
`ifdef SERIAL_SUBTRACTOR_BIN_EN
      rbin = 1'($urandom_range(0, 1));
`else
      rbin = 1'b0;
`endif
      do_accept(ra, rbv, rbin, ac);
      if (i > 0) chk($sformatf("rnd%0d_thru", i), ac - prev_ac, W + 2);
      prev_ac = ac;
      wait_res(rd, rb, lat);
      full = {1'b0, ra} - {1'b0, rbv} - {{W{1'b0}}, rbin};
      chk($sformatf("rnd%0d_d", i), 32'(rd), 32'(full[W-1:0]));
      chk($sformatf("rnd%0d_bout", i), 32'(rb), 32'(full[W]));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
